main_memory_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 35 +++
 rtl/main_memory_responder_array.sv | 26 ++
 rtl/main_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_main_memory_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and address helpers for the main-memory responder.
package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RWAIT = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WWAIT = 3'd4
    } mem_resp_state_t;

    localparam int unsigned BYTE_OFF_W = 2;

    // Beat counter width: log2 of the burst length.
    function automatic int unsigned beat_cnt_w(input int unsigned words_per_line);
        return (words_per_line < 2) ? 1 : $clog2(words_per_line);
    endfunction

    // Latency counter width: must hold LATENCY-1.
    function automatic int unsigned lat_cnt_w(input int unsigned latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

    // Word index of a byte address; byte-lane bits are dropped.
    function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
        return byte_addr >> BYTE_OFF_W;
    endfunction

    // Line-aligned word index.
    function automatic logic [63:0] line_base(input logic [63:0] widx,
                                              input int unsigned words_per_line);
        return widx & ~(64'(words_per_line) - 64'd1);
    endfunction

endpackage

// File: rtl/main_memory_responder_array.sv
// Word storage: synchronous write, combinational read. Not cleared by reset.
module mem_resp_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned AIDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AIDX_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: serves line fills and writebacks as word bursts
// with a fixed access latency.
// Optional: MEMRESP_CRITICAL_WORD_FIRST_EN starts read bursts at the
// requested word and wraps within the line.
module main_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned LATENCY        = 20,
    parameter int unsigned DEPTH_WORDS    = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wvalid,
    input  logic [DATA_W-1:0] wdata,
    output logic              wready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    output logic              wdone
);

    localparam int unsigned BEAT_W = beat_cnt_w(WORDS_PER_LINE);
    localparam int unsigned LAT_W  = lat_cnt_w(LATENCY);
    localparam int unsigned AIDX_W = $clog2(DEPTH_WORDS);

    mem_resp_state_t   state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] off_q, off_d;
    logic [LAT_W-1:0]  lcnt_q, lcnt_d;
    logic [AIDX_W-1:0] base_q, base_d;
    logic              rvalid_d, rlast_d, wdone_d;
    logic [DATA_W-1:0] rdata_d;

    logic              mem_we_c;
    logic [AIDX_W-1:0] mem_waddr_c;
    logic [AIDX_W-1:0] mem_raddr_c;
    logic [DATA_W-1:0] mem_rdata_c;

    // Line base is aligned, so adding the in-line offset never carries out of the line.
    assign mem_raddr_c = base_q + AIDX_W'(BEAT_W'(off_q + beat_q));
    assign mem_waddr_c = base_q + AIDX_W'(beat_q);

    mem_resp_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AIDX_W      (AIDX_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (mem_waddr_c),
        .wdata   (wdata),
        .raddr   (mem_raddr_c),
        .rdata_c (mem_rdata_c)
    );

    // Next-state, counters and next output values
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        off_d    = off_q;
        lcnt_d   = lcnt_q;
        base_d   = base_q;
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        wdone_d  = 1'b0;
        rdata_d  = rdata;
        mem_we_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d = AIDX_W'(line_base(word_index(64'(req_addr)), WORDS_PER_LINE));
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
                    off_d  = BEAT_W'(word_index(64'(req_addr)));
`else
                    off_d  = '0;
`endif
                    beat_d  = '0;
                    lcnt_d  = LAT_W'(LATENCY - 1);
                    state_d = req_we ? WDATA : RWAIT;
                end
            end
            RWAIT: begin
                if (lcnt_q == '0) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata_c;
                    beat_d   = beat_q + BEAT_W'(1);
                    state_d  = RDATA;
                end else begin
                    lcnt_d = lcnt_q - LAT_W'(1);
                end
            end
            RDATA: begin
                rvalid_d = 1'b1;
                rdata_d  = mem_rdata_c;
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                    rlast_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (wvalid) begin
                    mem_we_c = ~reset;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                        lcnt_d  = LAT_W'(LATENCY - 1);
                        state_d = WWAIT;
                    end
                end
            end
            WWAIT: begin
                if (lcnt_q == '0) begin
                    wdone_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            off_q     <= '0;
            lcnt_q    <= '0;
            base_q    <= '0;
            req_ready <= 1'b1;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            wdone     <= 1'b0;
            rdata     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            off_q     <= off_d;
            lcnt_q    <= lcnt_d;
            base_q    <= base_d;
            req_ready <= (state_d == IDLE);
            wready    <= (state_d == WDATA);
            rvalid    <= rvalid_d;
            rlast     <= rlast_d;
            wdone     <= wdone_d;
            rdata     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: vector table, corner-case
// sequences and randomized traffic against a word-array reference model.
module tb_main_memory_responder;

    localparam int unsigned LAT   = 20;
    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 16384;

    typedef logic [31:0] line_t [4];
    typedef int gaps_t [4];
    typedef struct {
        bit          we;
        logic [31:0] addr;
        line_t       data;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic        wvalid;
    logic [31:0] wdata;
    logic        wready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        wdone;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_m [int];

    main_memory_responder #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .WORDS_PER_LINE (W),
        .LATENCY        (LAT),
        .DEPTH_WORDS    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wready    (wready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .rlast     (rlast),
        .wdone     (wdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Array index of beat b within the line holding addr (aliasing via mod DEPTH).
    function automatic int aidx(input logic [31:0] addr, input int b);
        logic [31:0] w;
        w = ((addr >> 2) & 32'hFFFF_FFFC) + 32'(b);
        return int'(w % 32'(DEPTH));
    endfunction

    function automatic int start_off(input logic [31:0] addr);
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
        return int'((addr >> 2) % 32'(W));
`else
        return 0;
`endif
    endfunction

    function automatic bit model_has(input logic [31:0] addr);
        for (int b = 0; b < 4; b++)
            if (!mem_m.exists(aidx(addr, b))) return 1'b0;
        return 1'b1;
    endfunction

    // Expected read beats in delivery order.
    task automatic model_line(input logic [31:0] addr, output line_t r);
        for (int b = 0; b < 4; b++)
            r[b] = mem_m[aidx(addr, (start_off(addr) + b) % 4)];
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            tick();
            k++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input line_t d, input gaps_t gaps);
        int k;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        chk("wready_on", 32'(wready), 32'd1);
        for (int b = 0; b < 4; b++) begin
            repeat (gaps[b]) tick();
            wvalid = 1'b1;
            wdata  = d[b];
            mem_m[aidx(addr, b)] = d[b];
            tick();
            wvalid = 1'b0;
        end
        chk("wready_off", 32'(wready), 32'd0);
        k = 0;
        while (!wdone && k <= int'(LAT) + 5) begin
            tick();
            k++;
        end
        chk("wdone_latency", 32'(k), 32'(LAT));
        chk("ready_with_wdone", 32'(req_ready), 32'd1);
        tick();
        chk("wdone_pulse", 32'(wdone), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input line_t exp,
                           input bit hold_req, input bit poke_w);
        int k;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        tick();
        if (!hold_req) req_valid = 1'b0;
        k = 0;
        while (!rvalid && k <= int'(LAT) + 5) begin
            if (hold_req) chk("ready_busy", 32'(req_ready), 32'd0);
            tick();
            k++;
        end
        req_valid = 1'b0;
        chk("rd_latency", 32'(k), 32'(LAT));
        for (int b = 0; b < 4; b++) begin
            chk("rd_valid", 32'(rvalid), 32'd1);
            chk("rd_data", rdata, exp[b]);
            chk("rd_last", 32'(rlast), 32'(b == 3));
            if (poke_w) begin
                wvalid = 1'b1;
                wdata  = 32'hDEAD_BEEF;
            end
            tick();
        end
        wvalid = 1'b0;
        chk("rd_end", 32'(rvalid), 32'd0);
        if (hold_req) begin
            k = 0;
            for (int i = 0; i < int'(LAT) + 4; i++) begin
                if (rvalid) k++;
                tick();
            end
            chk("no_second_burst", 32'(k), 32'd0);
        end
    endtask

    initial begin
        vec_t        vecs [6];
        line_t       exp;
        line_t       d;
        gaps_t       g0;
        gaps_t       gg;
        logic [31:0] a;
        int          k;

        g0 = '{0, 0, 0, 0};
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_wdone", 32'(wdone), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Vector table: writes supply beats, reads supply expected beats in delivery order.
        vecs[0].we = 1'b1; vecs[0].addr = 32'h0000_4012;
        vecs[0].data = '{32'h1234_5678, 32'h1, 32'h2, 32'h3};
        vecs[1].we = 1'b0; vecs[1].addr = 32'h0000_4012;
        vecs[1].data = '{32'h1234_5678, 32'h1, 32'h2, 32'h3};
        vecs[2].we = 1'b1; vecs[2].addr = 32'h0000_8010;
        vecs[2].data = '{32'h8765_4321, 32'h11, 32'h22, 32'h33};
        vecs[3].we = 1'b0; vecs[3].addr = 32'h0000_4010;
        vecs[3].data = '{32'h1234_5678, 32'h1, 32'h2, 32'h3};
        vecs[4].we = 1'b0; vecs[4].addr = 32'h0000_8010;
        vecs[4].data = '{32'h8765_4321, 32'h11, 32'h22, 32'h33};
        vecs[5].we = 1'b0; vecs[5].addr = 32'h0000_4018;
`ifdef MEMRESP_CRITICAL_WORD_FIRST_EN
        vecs[5].data = '{32'h2, 32'h3, 32'h1234_5678, 32'h1};
`else
        vecs[5].data = '{32'h1234_5678, 32'h1, 32'h2, 32'h3};
`endif
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data, g0);
            else            do_read(vecs[i].addr, vecs[i].data, 1'b0, 1'b0);
        end

        // req_valid held through RWAIT, then wvalid poked during RDATA.
        exp = '{32'h1234_5678, 32'h1, 32'h2, 32'h3};
        do_read(32'h0000_4010, exp, 1'b1, 1'b0);
        do_read(32'h0000_4010, exp, 1'b0, 1'b1);
        do_read(32'h0000_4010, exp, 1'b0, 1'b0);

        // Gapped write beats on cycles 0, 2, 5, 6.
        d  = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
        gg = '{0, 1, 2, 0};
        do_write(32'h0000_0100, d, gg);
        do_read(32'h0000_0100, d, 1'b0, 1'b0);

        // Reset during beat 2 of a read, then a clean read.
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0100;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!rvalid && k <= int'(LAT) + 5) begin
            tick();
            k++;
        end
        chk("rst_burst_latency", 32'(k), 32'(LAT));
        tick();
        tick();
        chk("rst_burst_beat2", rdata, d[2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rlast", 32'(rlast), 32'd0);
        do_read(32'h0000_0100, d, 1'b0, 1'b0);

        // Randomized traffic on a small line pool with random upper (aliasing) bits.
        for (int i = 0; i < 40; i++) begin
            a = {16'($urandom), 12'(($urandom_range(0, 5) * 13) + 40), 4'($urandom)};
            if ($urandom_range(0, 1) == 1 || !model_has(a)) begin
                for (int b = 0; b < 4; b++) begin
                    d[b]  = $urandom;
                    gg[b] = int'($urandom_range(0, 2));
                end
                do_write(a, d, gg);
            end else begin
                model_line(a, exp);
                do_read(a, exp, 1'b0, 1'b0);
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
